// File: rtl/tetris_player.sv
// Tetris placement player: scans the host board row by row, asks an evaluator for a placement, commits it.
// Latency: 2 cycles per row (ROWS+1 per scan with PIPE_FETCH_EN), then evaluator wait, then one commit cycle.
// Backpressure: host_ready low stalls tile accept, row issue and commit; eval_req holds until eval_ack.
//
// Optional build macro: PIPE_FETCH_EN overlaps row issue with row capture.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   host_ready                 host can accept a tile / serve a row / take a commit
//   player_ready               high from the first clock edge after reset release
//   tile_type                  incoming tile code, 1..7 legal (1 = O, 7 = I)
//   row_req, row               row read strobe and row index (0 = top)
//   row_info                   row contents, valid the cycle after row_req
//   board                      captured snapshot, bit r*COLS+c = row_info[c] of row r
//   eval_req, eval_ack         evaluator handshake
//   eval_col, eval_rot         evaluator choice, column counted from the right edge
//   col, rotation              left anchor column and rotation of the placed tile
//   set_tile                   one-cycle commit strobe
module tetris_player #(
    parameter int ROWS  = 20,
    parameter int COLS  = 10,
    parameter int ROW_W = 6,
    parameter int COL_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   host_ready,
    output logic                   player_ready,
    input  logic [3:0]             tile_type,
    output logic                   row_req,
    output logic [ROW_W-1:0]       row,
    input  logic [COLS-1:0]        row_info,
    output logic [ROWS*COLS-1:0]   board,
    output logic                   eval_req,
    input  logic                   eval_ack,
    input  logic [COL_W-1:0]       eval_col,
    input  logic [1:0]             eval_rot,
    output logic [COL_W-1:0]       col,
    output logic [1:0]             rotation,
    output logic                   set_tile
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        EVAL,
        SET
    } state_t;

    // Column arithmetic is done three bits wider than COL_W so that
    // COLS-1-eval_col-off can go negative without wrapping.
    localparam int CW   = COL_W + 3;
    localparam int CMAX = COLS - 1;

    state_t                 r_state;
    logic [2:0]             r_tile;
    logic [ROW_W-1:0]       r_index;
    logic [ROWS*COLS-1:0]   r_board;
    logic                   r_eval_req;
    logic                   r_set_tile;
    logic [COL_W-1:0]       r_col;
    logic [1:0]             r_rot;
    logic                   r_player_ready;

`ifdef PIPE_FETCH_EN
    // Row issued last cycle; its data arrives on row_info this cycle.
    logic                   r_cap_vld;
    logic [ROW_W-1:0]       r_cap_row;
`endif

    logic                   w_tile_ok;
    logic                   w_issue;
    logic                   w_last_row;
    logic [1:0]             w_off;
    logic signed [CW-1:0]   w_col_s;
    logic [COL_W-1:0]       w_col;

    // Codes 1..7 only: nonzero and bit 3 clear.
    assign w_tile_ok  = (tile_type != 4'd0) && !tile_type[3];

    // The request is a decode of state and host_ready so that a busy host
    // sees no strobe at all in the cycle it is busy.
    assign w_issue    = (r_state == FETCH) && host_ready;
    assign w_last_row = (r_index == ROW_W'(ROWS - 1));

    // Distance from the tile's bounding-box left edge to the column the
    // evaluator reports, for the rotations where they differ.
    always_comb begin
        w_off = 2'd0;
        case (r_tile)
            3'd1: w_off = 2'd0;
            3'd7: begin
                if (eval_rot == 2'd1)      w_off = 2'd2;
                else if (eval_rot == 2'd3) w_off = 2'd1;
                else                       w_off = 2'd0;
            end
            default: w_off = (eval_rot == 2'd1) ? 2'd1 : 2'd0;
        endcase
    end

    // Convert right-referenced column to a left anchor, clamped to the board.
    always_comb begin
        w_col_s = CW'(CMAX) - CW'(eval_col) - CW'(w_off);
        w_col   = '0;
        if (w_col_s < 0)
            w_col = '0;
        else if (w_col_s > CW'(CMAX))
            w_col = COL_W'(CMAX);
        else
            w_col = w_col_s[COL_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_tile         <= '0;
            r_index        <= '0;
            r_board        <= '0;
            r_eval_req     <= 1'b0;
            r_set_tile     <= 1'b0;
            r_col          <= '0;
            r_rot          <= '0;
            r_player_ready <= 1'b0;
`ifdef PIPE_FETCH_EN
            r_cap_vld      <= 1'b0;
            r_cap_row      <= '0;
`endif
        end else begin
            r_player_ready <= 1'b1;
            r_set_tile     <= 1'b0;

`ifdef PIPE_FETCH_EN
            // Capture runs one cycle behind issue, independent of
            // host_ready, so a row in flight when the host stalls still lands.
            r_cap_vld <= w_issue;
            if (w_issue)
                r_cap_row <= r_index;
            if (r_cap_vld)
                r_board[int'(r_cap_row)*COLS +: COLS] <= row_info;
`endif

            case (r_state)
                IDLE: begin
                    if (host_ready && w_tile_ok) begin
                        r_tile  <= tile_type[2:0];
                        r_index <= '0;
                        r_state <= FETCH;
                    end
                end

                FETCH: begin
`ifdef PIPE_FETCH_EN
                    // Issue back to back; index stays on the last row once
                    // it has been issued.
                    if (host_ready) begin
                        if (w_last_row)
                            r_state <= CAPTURE;
                        else
                            r_index <= r_index + ROW_W'(1);
                    end
`else
                    if (host_ready)
                        r_state <= CAPTURE;
`endif
                end

                CAPTURE: begin
`ifdef PIPE_FETCH_EN
                    // The final row is in flight and is written by the
                    // capture stage above during this cycle.
                    r_state    <= EVAL;
                    r_eval_req <= 1'b1;
`else
                    r_board[int'(r_index)*COLS +: COLS] <= row_info;
                    r_index <= r_index + ROW_W'(1);
                    if (w_last_row) begin
                        r_state    <= EVAL;
                        r_eval_req <= 1'b1;
                    end else begin
                        r_state    <= FETCH;
                    end
`endif
                end

                EVAL: begin
                    if (eval_ack && r_eval_req) begin
                        r_eval_req <= 1'b0;
                        r_col      <= w_col;
                        r_rot      <= eval_rot;
                        r_state    <= SET;
                    end
                end

                SET: begin
                    if (host_ready) begin
                        r_set_tile <= 1'b1;
                        r_state    <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign player_ready = r_player_ready;
    assign row_req      = w_issue;
    assign row          = r_index;
    assign board        = r_board;
    assign eval_req     = r_eval_req;
    assign col          = r_col;
    assign rotation     = r_rot;
    assign set_tile     = r_set_tile;

endmodule
